// File: rtl/alu_operand_pipe.sv
// alu_operand_pipe: registered ALU operand source mux with a 2-entry skid
// buffer (valid/ready on both sides) and flush for branch/jump redirects.
// Optional performance counters: define ALU_OPERAND_PERF_CNT_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_EMPTY | no entry held; out_valid=0, in_ready=1
// ST_ONE   | main register holds a pair; out_valid=1, in_ready=1
// ST_TWO   | main and skid both hold pairs; out_valid=1, in_ready=0
module alu_operand_pipe #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
`ifdef ALU_OPERAND_PERF_CNT_EN
  ,parameter int CNT_W  = 32
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SRC*WIDTH-1:0] src_a_bus,
  input  logic [NUM_SRC*WIDTH-1:0] src_b_bus,
  input  logic [SEL_W-1:0]         sel_a,
  input  logic [SEL_W-1:0]         sel_b,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  output logic                     sel_err
`ifdef ALU_OPERAND_PERF_CNT_EN
  ,output logic [CNT_W-1:0]        xfer_cnt,
  output logic [CNT_W-1:0]         stall_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] main_a_q, main_a_d;
  logic [WIDTH-1:0] main_b_q, main_b_d;
  logic [WIDTH-1:0] skid_a_q, skid_a_d;
  logic [WIDTH-1:0] skid_b_q, skid_b_d;
  logic             sel_err_q, sel_err_d;

  logic [WIDTH-1:0] new_a, new_b;
  logic             bad_a, bad_b;
  logic             accept, xfer, load_new;

  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  // A flushed accept is dropped: it neither loads data nor flags sel_err.
  assign load_new = accept && !flush;

  // Operand selection; an out-of-range index yields zero and flags an error.
  always_comb begin
    new_a = '0;
    new_b = '0;
    bad_a = 1'b1;
    bad_b = 1'b1;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_a == SEL_W'(k)) begin
        new_a = src_a_bus[k*WIDTH +: WIDTH];
        bad_a = 1'b0;
      end
      if (sel_b == SEL_W'(k)) begin
        new_b = src_b_bus[k*WIDTH +: WIDTH];
        bad_b = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  // Next-state logic; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_d = ST_ONE;
        ST_ONE: begin
          if (accept && !xfer)      state_d = ST_TWO;
          else if (!accept && xfer) state_d = ST_EMPTY;
        end
        ST_TWO:   if (xfer) state_d = ST_ONE;
        default:  state_d = ST_EMPTY;
      endcase
    end
  end

  // Handshake outputs decoded from the state register only.
  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    in_ready  = (state_q != ST_TWO);
  end

  // Data movement between input, skid and main registers.
  always_comb begin
    main_a_d  = main_a_q;
    main_b_d  = main_b_q;
    skid_a_d  = skid_a_q;
    skid_b_d  = skid_b_q;
    sel_err_d = sel_err_q | (load_new & (bad_a | bad_b));
    case (state_q)
      ST_EMPTY: begin
        if (load_new) begin
          main_a_d = new_a;
          main_b_d = new_b;
        end
      end
      ST_ONE: begin
        if (load_new && xfer) begin
          main_a_d = new_a;
          main_b_d = new_b;
        end else if (load_new) begin
          skid_a_d = new_a;
          skid_b_d = new_b;
        end
      end
      ST_TWO: begin
        if (xfer) begin
          main_a_d = skid_a_q;
          main_b_d = skid_b_q;
        end
      end
      default: ;
    endcase
  end

  // Data and sticky error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_a_q  <= '0;
      main_b_q  <= '0;
      skid_a_q  <= '0;
      skid_b_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      main_a_q  <= main_a_d;
      main_b_q  <= main_b_d;
      skid_a_q  <= skid_a_d;
      skid_b_q  <= skid_b_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign op_a    = main_a_q;
  assign op_b    = main_b_q;
  assign sel_err = sel_err_q;

`ifdef ALU_OPERAND_PERF_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Free-running wrap-around counters; flush leaves them alone.
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer)                 xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
    if (in_valid && !in_ready) stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_pipe.sv
// Bench for alu_operand_pipe: directed scenarios plus random traffic, all
// checked against a queue-based reference of the operand buffer.
module tb_alu_operand_pipe;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- main instance, NUM_SRC = 4 ----------------
  logic          rst, in_valid, in_ready, flush, out_valid, out_ready, sel_err;
  logic [4*W-1:0] src_a_bus, src_b_bus;
  logic [1:0]    sel_a, sel_b;
  logic [W-1:0]  op_a, op_b;
  logic [W-1:0]  src_a [4];
  logic [W-1:0]  src_b [4];
`ifdef ALU_OPERAND_PERF_CNT_EN
  logic [31:0]   xfer_cnt, stall_cnt;
`endif

  always_comb begin
    src_a_bus = '0;
    src_b_bus = '0;
    for (int k = 0; k < 4; k++) begin
      src_a_bus[k*W +: W] = src_a[k];
      src_b_bus[k*W +: W] = src_b[k];
    end
  end

  alu_operand_pipe #(.WIDTH(W), .NUM_SRC(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .src_a_bus(src_a_bus), .src_b_bus(src_b_bus), .sel_a(sel_a), .sel_b(sel_b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .op_a(op_a), .op_b(op_b), .sel_err(sel_err)
`ifdef ALU_OPERAND_PERF_CNT_EN
    , .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
`endif
  );

  // ---------------- second instance, NUM_SRC = 3 ----------------
  logic          rst3, in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
  logic [3*W-1:0] src_a_bus3, src_b_bus3;
  logic [1:0]    sel_a3, sel_b3;
  logic [W-1:0]  op_a3, op_b3;
`ifdef ALU_OPERAND_PERF_CNT_EN
  logic [31:0]   xfer_cnt3, stall_cnt3;
`endif

  alu_operand_pipe #(.WIDTH(W), .NUM_SRC(3)) u_dut3 (
    .clk(clk), .rst(rst3), .in_valid(in_valid3), .in_ready(in_ready3),
    .src_a_bus(src_a_bus3), .src_b_bus(src_b_bus3), .sel_a(sel_a3), .sel_b(sel_b3),
    .flush(flush3), .out_valid(out_valid3), .out_ready(out_ready3),
    .op_a(op_a3), .op_b(op_b3), .sel_err(sel_err3)
`ifdef ALU_OPERAND_PERF_CNT_EN
    , .xfer_cnt(xfer_cnt3), .stall_cnt(stall_cnt3)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
  } pair_t;

  pair_t       mq[$];
  bit          m_known = 1'b0;
  bit          m_err   = 1'b0;
  int unsigned m_xfer  = 0;
  int unsigned m_stall = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: compare DUT against the model mid-cycle, advance the
  // model with the inputs the coming edge will sample, then cross the edge.
  task automatic step();
    bit   xf, ac;
    pair_t p;
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", out_valid, mq.size() > 0);
      chk("in_ready", in_ready, mq.size() < 2);
      if (mq.size() > 0) begin
        chk("op_a", op_a, mq[0].a);
        chk("op_b", op_b, mq[0].b);
      end
      chk("sel_err", sel_err, m_err);
`ifdef ALU_OPERAND_PERF_CNT_EN
      chk("xfer_cnt", xfer_cnt, m_xfer);
      chk("stall_cnt", stall_cnt, m_stall);
`endif
    end
    if (rst) begin
      mq.delete();
      m_err   = 1'b0;
      m_xfer  = 0;
      m_stall = 0;
      m_known = 1'b1;
    end else if (m_known) begin
      xf = (mq.size() > 0) && out_ready;
      ac = in_valid && (mq.size() < 2);
      if (xf) m_xfer++;
      if (in_valid && mq.size() == 2) m_stall++;
      if (flush) mq.delete();
      else begin
        if (xf) void'(mq.pop_front());
        if (ac) begin
          p.a = src_a[sel_a];
          p.b = src_b[sel_b];
          mq.push_back(p);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [W-1:0] src_a3 [3];
  logic [W-1:0] src_b3 [3];
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      src_a_bus3[k*W +: W] = src_a3[k];
      src_b_bus3[k*W +: W] = src_b3[k];
    end
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    sel_a = '0; sel_b = '0;
    for (int k = 0; k < 4; k++) begin src_a[k] = '0; src_b[k] = '0; end
    rst3 = 1'b1; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
    sel_a3 = '0; sel_b3 = '0;
    for (int k = 0; k < 3; k++) begin src_a3[k] = 32'h100 + k; src_b3[k] = 32'h200 + k; end

    step();
    step();
    rst = 1'b0;
    rst3 = 1'b0;
    chk("rst_op_a", op_a, 0);
    chk("rst_op_b", op_b, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);

    // Basic select
    src_a[0] = 32'h11; src_a[1] = 32'h22; src_a[2] = 32'h33; src_a[3] = 32'h44;
    src_b[0] = 32'hA0; src_b[1] = 32'hB0; src_b[2] = 32'hC0; src_b[3] = 32'hD0;
    sel_a = 2'd2; sel_b = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("basic_valid", out_valid, 1);
    chk("basic_op_a", op_a, 32'h33);
    chk("basic_op_b", op_b, 32'hB0);
    step();
    chk("basic_drain", out_valid, 0);

    // Back-pressure: P0, P1 accepted, P2 waits four cycles
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1;
    sel_a = 2'd0; sel_b = 2'd0;
    src_a[0] = 32'hA0A0_0000; src_b[0] = 32'hB0B0_0000; step();
    src_a[0] = 32'hA0A0_0001; src_b[0] = 32'hB0B0_0001; step();
    src_a[0] = 32'hA0A0_0002; src_b[0] = 32'hB0B0_0002;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", in_ready, 0);
      chk("bp_hold_a", op_a, 32'hA0A0_0000);
    end
    out_ready = 1'b1;
    step();
    chk("bp_p1", op_a, 32'hA0A0_0001);
    step();
    in_valid = 1'b0;
    chk("bp_p2", op_a, 32'hA0A0_0002);
    step();
    chk("bp_empty", out_valid, 0);
`ifdef ALU_OPERAND_PERF_CNT_EN
    chk("bp_xfer_cnt", xfer_cnt, 3);
    chk("bp_stall_cnt", stall_cnt, 4);
`endif

    // Streaming: 16 back-to-back pairs
    n = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      sel_a = 2'(i); sel_b = 2'(i + 1);
      src_a[i % 4] = 32'h5000 + i; src_b[(i + 1) % 4] = 32'h6000 + i;
      step();
      if (out_valid === 1'b1) n++;
    end
    in_valid = 1'b0;
    chk("stream_outputs", n, 16);
    step();
    chk("stream_done", out_valid, 0);

    // Flush in TWO together with a new input
    out_ready = 1'b0; in_valid = 1'b1; sel_a = 2'd3; sel_b = 2'd3;
    src_a[3] = 32'h7000_0001; step();
    src_a[3] = 32'h7000_0002; step();
    chk("fl_full", in_ready, 0);
    flush = 1'b1; src_a[3] = 32'h7000_0003; step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_valid", out_valid, 0);
    step();
    chk("fl_stay_empty", out_valid, 0);

    // Invalid select on the three-source instance
    sel_a3 = 2'd3; sel_b3 = 2'd1; in_valid3 = 1'b1; out_ready3 = 1'b1;
    step();
    in_valid3 = 1'b0;
    chk("inv_valid", out_valid3, 1);
    chk("inv_op_a", op_a3, 0);
    chk("inv_op_b", op_b3, 32'h201);
    chk("inv_err", sel_err3, 1);
    sel_a3 = 2'd0;
    in_valid3 = 1'b1;
    step(); step();
    in_valid3 = 1'b0;
    chk("inv_ok_a", op_a3, 32'h100);
    chk("inv_err_sticky", sel_err3, 1);
    rst3 = 1'b1; step(); rst3 = 1'b0;
    chk("inv_rst_err", sel_err3, 0);
    chk("inv_rst_op_a", op_a3, 0);
    chk("inv_rst_op_b", op_b3, 0);
    chk("inv_rst_ready", in_ready3, 1);
    chk("inv_rst_valid", out_valid3, 0);
`ifdef ALU_OPERAND_PERF_CNT_EN
    chk("inv_rst_xfer", xfer_cnt3, 0);
`endif

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < 4; k++) begin
        src_a[k] = $urandom;
        src_b[k] = $urandom;
      end
      sel_a     = 2'($urandom_range(0, 3));
      sel_b     = 2'($urandom_range(0, 3));
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      rst       = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
